// File: rtl/seg7_pkg.sv
// Shared types and segment patterns for the 4-digit scanned display.
// Patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;
    localparam seg7_t SEG_DASH  = 7'h3F;

    localparam seg7_t SEG_0 = 7'h40;
    localparam seg7_t SEG_1 = 7'h79;
    localparam seg7_t SEG_2 = 7'h24;
    localparam seg7_t SEG_3 = 7'h30;
    localparam seg7_t SEG_4 = 7'h19;
    localparam seg7_t SEG_5 = 7'h12;
    localparam seg7_t SEG_6 = 7'h02;
    localparam seg7_t SEG_7 = 7'h78;
    localparam seg7_t SEG_8 = 7'h00;
    localparam seg7_t SEG_9 = 7'h10;

endpackage

// File: rtl/seg7_dec.sv
// BCD to active-low 7-segment decoder.
// Codes 10..15 are not BCD and show a dash so bad upstream data is visible.
module seg7_dec
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output seg7_t      o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan4.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Inputs are snapshotted once per frame so a digit never tears mid-scan.
module seg7_scan4
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       blank_lz,
    input  logic [3:0] dig0,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    input  logic [3:0] dig3,
    input  logic [3:0] dp_in,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [3:0]       r_snapDig [4];
    logic [3:0]       r_snapDp;
    logic             r_snapBlz;
    seg7_t            r_seg;
    logic             r_dp;
    logic [3:0]       r_an;

    logic             w_slotEnd;
    logic             w_frameEnd;
    logic             w_pastBlank;
    logic             w_lit;
    logic             w_lzBlank;
    logic [3:0]       w_curDig;
    seg7_t            w_decSeg;

    assign w_slotEnd  = (r_cnt == CNT_W'(SCAN_DIV - 1));
    assign w_frameEnd = w_slotEnd && (r_idx == 2'd3);

    // With no blank interval the compare would be trivially true, so drop it.
    generate
        if (BLANK_CYC == 0) begin : g_noBlank
            assign w_pastBlank = 1'b1;
        end else begin : g_blank
            assign w_pastBlank = (r_cnt >= CNT_W'(BLANK_CYC));
        end
    endgenerate

    assign w_lit     = en && w_pastBlank;
    assign w_curDig  = r_snapDig[r_idx];
    assign w_lzBlank = (r_idx == 2'd3) && r_snapBlz && (r_snapDig[3] == 4'd0);

    seg7_dec u_dec (
        .i_bcd (w_curDig),
        .o_seg (w_decSeg)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (w_slotEnd) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Capture on the frame wrap only, so all four digits come from one instant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                r_snapDig[i] <= 4'd0;
            end
            r_snapDp  <= 4'd0;
            r_snapBlz <= 1'b0;
        end else if (w_frameEnd) begin
            r_snapDig[0] <= dig0;
            r_snapDig[1] <= dig1;
            r_snapDig[2] <= dig2;
            r_snapDig[3] <= dig3;
            r_snapDp     <= dp_in;
            r_snapBlz    <= blank_lz;
        end
    end

    // A blanked leading zero still drives its anode so brightness stays uniform.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an  <= 4'b1111;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else if (w_lit) begin
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_lzBlank ? SEG_BLANK : w_decSeg;
            r_dp  <= w_lzBlank ? 1'b1 : ~r_snapDp[r_idx];
        end else begin
            r_an  <= 4'b1111;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end
    end

    assign seg = r_seg;
    assign dp  = r_dp;
    assign an  = r_an;

endmodule

// File: tb/tb_seg7_scan4.sv
// Scoreboard bench for seg7_scan4: a cycle-count reference model queues the
// expected display output each edge; a monitor pops and compares it.
module tb_seg7_scan4;

    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       blank_lz;
    logic [3:0] dig0, dig1, dig2, dig3;
    logic [3:0] dp_in;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } outVec_t;

    outVec_t expQ[$];
    outVec_t monVec;
    outVec_t modVec;

    int vectors     = 0;
    int miscompares = 0;
    int scanChecks  = 0;

    int         edgesSinceReset;
    int         mSlot;
    int         mPhase;
    logic [3:0] mDig [4];
    logic [3:0] mDp;
    logic       mBlz;

    seg7_scan4 #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .blank_lz (blank_lz),
        .dig0     (dig0),
        .dig1     (dig1),
        .dig2     (dig2),
        .dig3     (dig3),
        .dp_in    (dp_in),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] refPattern(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [3:0] expAn,
                               input logic [6:0] expSeg, input logic expDp);
        vectors++;
        if (an !== expAn || seg !== expSeg || dp !== expDp) begin
            miscompares++;
            $display("[TB] FAIL %s @%0t: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                     name, $time, an, seg, dp, expAn, expSeg, expDp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] d3, input logic [3:0] d2,
                                 input logic [3:0] d1, input logic [3:0] d0,
                                 input logic [3:0] dpIn, input logic blz, input logic ena);
        dig3     = d3;
        dig2     = d2;
        dig1     = d1;
        dig0     = d0;
        dp_in    = dpIn;
        blank_lz = blz;
        en       = ena;
    endtask

    task automatic runCycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Reference model: slot and phase come straight from the number of edges
    // since reset; inputs are sampled every FRAME edges as the display data.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            edgesSinceReset = 0;
            for (int i = 0; i < 4; i++) mDig[i] = 4'd0;
            mDp  = 4'd0;
            mBlz = 1'b0;
            expQ.delete();
        end else begin
            mSlot  = (edgesSinceReset / SCAN_DIV) % 4;
            mPhase = edgesSinceReset % SCAN_DIV;
            modVec.an  = 4'b1111;
            modVec.seg = 7'h7F;
            modVec.dp  = 1'b1;
            if (en && mPhase >= BLANK_CYC) begin
                modVec.an[mSlot] = 1'b0;
                if (!(mSlot == 3 && mBlz && mDig[3] == 4'd0)) begin
                    modVec.seg = refPattern(mDig[mSlot]);
                    modVec.dp  = ~mDp[mSlot];
                end
            end
            expQ.push_back(modVec);
            if (edgesSinceReset % FRAME == FRAME - 1) begin
                mDig[0] = dig0;
                mDig[1] = dig1;
                mDig[2] = dig2;
                mDig[3] = dig3;
                mDp     = dp_in;
                mBlz    = blank_lz;
            end
            edgesSinceReset++;
        end
    end

    // Monitor: every cycle the DUT presents a display word; compare it
    // against the oldest queued expectation, away from the active edge.
    always @(negedge clk) begin
        if (rst === 1'b1 && expQ.size() > 0) begin
            monVec = expQ.pop_front();
            scanChecks++;
            checkOutput("scan", monVec.an, monVec.seg, monVec.dp);
        end
    end

    initial begin
        applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0, 1'b1);
        rst = 1'b1;
        #2 rst = 1'b0;
        #2 checkOutput("resetState", 4'b1111, 7'h7F, 1'b1);
        runCycles(2);
        rst = 1'b1;

        // First frame shows the zero snapshot, then 1-2-3-4; dig1 changes mid-frame.
        runCycles(42);
        dig1 = 4'd5;
        runCycles(80);

        // Leading-zero blanking on and off.
        applyStimulus(4'd0, 4'd2, 4'd5, 4'd4, 4'b0000, 1'b1, 1'b1);
        runCycles(2 * FRAME);
        blank_lz = 1'b0;
        runCycles(2 * FRAME);

        // Invalid BCD and a single decimal point.
        applyStimulus(4'd1, 4'hC, 4'd5, 4'd4, 4'b0100, 1'b0, 1'b1);
        runCycles(2 * FRAME);

        // Drop enable mid-slot for five cycles.
        runCycles(3);
        en = 1'b0;
        runCycles(5);
        en = 1'b1;
        runCycles(FRAME);

        // Asynchronous reset mid-slot, checked before the next clock edge.
        rst = 1'b0;
        runCycles(1);
        rst = 1'b1;
        runCycles(20);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 checkOutput("asyncReset", 4'b1111, 7'h7F, 1'b1);
        runCycles(3);
        rst = 1'b1;
        runCycles(FRAME + 4);

        // Randomized inputs changing at arbitrary points in the frame.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                dig3     = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                dig2     = 4'($urandom_range(0, 15));
                dig1     = 4'($urandom_range(0, 15));
                dig0     = 4'($urandom_range(0, 15));
                dp_in    = 4'($urandom_range(0, 15));
                blank_lz = 1'($urandom_range(0, 1));
            end
            en = ($urandom_range(0, 15) != 0);
            runCycles(1);
        end

        vectors++;
        if (scanChecks < 1800) begin
            miscompares++;
            $display("[TB] FAIL monitorActivity: got %0d scan checks, expected at least 1800", scanChecks);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_scan4.md
Name: seg7_scan4

Overview:
- Downstream display stage for the clock counters.
- Takes four BCD digits (seconds ones/tens, minutes ones/tens) from the cnt60 chain and drives a 4-digit common-anode 7-segment display by time-multiplexed scanning.
- Per-digit anti-ghosting blank interval, frame-synchronous input snapshot (no tearing mid-frame), leading-zero blanking of the top digit, invalid-BCD indication.

Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot; legal range ≥ 4.
- BLANK_CYC, 16: cycles at the start of each slot with all anodes off; must satisfy 0 ≤ BLANK_CYC < SCAN_DIV.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  display enable; 0 forces all anodes off (scan keeps running).
- blank_lz  in  1  1 = blank digit 3 when its snapshot value is 0.
- dig0  in  4  BCD seconds ones.
- dig1  in  4  BCD seconds tens.
- dig2  in  4  BCD minutes ones.
- dig3  in  4  BCD minutes tens.
- dp_in  in  4  decimal point request per digit, bit i = digit i, 1 = lit.
- seg  out  7  segments, active-low, seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, active-low.
- an  out  4  anode selects, active-low, an[i] = digit i.

Behaviour:
- Reset (rst=0, async):
  - Prescaler cnt=0, slot index idx=0, snapshot registers=0.
  - Outputs: an=4'b1111, seg=7'h7F, dp=1.
- Prescaler:
  - cnt counts 0..SCAN_DIV-1.
  - At cnt==SCAN_DIV-1: cnt←0 and idx←(idx+1) mod 4; otherwise cnt←cnt+1.
- Snapshot:
  - On the edge where cnt==SCAN_DIV-1 and idx==3 (frame wrap), dig0..3, dp_in and blank_lz are captured.
  - Displayed data changes only at frame boundaries.
  - Input changes at any other time have no effect until the next wrap.
- Output pipeline:
  - seg/dp/an are registered from the current (idx, cnt, snapshot) state, so outputs lag that state by one cycle.
  - an[idx]=0 iff en=1 and cnt ≥ BLANK_CYC; all other anode bits are 1.
  - When all anodes are off, seg=7'h7F and dp=1.
- Decode (active-low, {g..a}):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19.
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Any value 10..15 shows "-" = 7'h3F.
- Leading-zero blank:
  - Applies only when the snapshot of blank_lz=1 and snapshot dig3==0.
  - Digit 3's slot then shows seg=7'h7F and dp=1, but an[3] still follows the normal scan timing.
- dp = ~dp_snapshot[idx] during the lit portion of each slot.
- en deasserted mid-slot: an→1111 on the next cycle; cnt, idx and snapshot keep running, so re-enable resumes the scan in phase.
- BLANK_CYC=0: no blank interval, and the digit is lit for the whole slot.
- Reset mid-frame: immediate return to the reset state; the first valid frame shows the zero snapshot until the first wrap.

Decomposition:
- Package seg7_pkg holds:
  - seg7_t typedef (7-bit active-low pattern).
  - Constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F.
  - The ten digit patterns.
- One combinational sub-module, seg7_dec: 4-bit BCD in → seg7_t out, including the invalid→dash rule.
- seg7_scan4 holds the prescaler, slot index, snapshot, anode/blank logic and output registers.

Test Plan:
All scenarios run with SCAN_DIV=8 and BLANK_CYC=2.
- Reset then release with inputs dig3..0=1,2,3,4 and en=1:
  - During the first frame the displayed data is the zero snapshot.
  - After the first wrap, digit 0 shows seg=7'h19 with an=4'b1110 for 6 of every 8 cycles, and an=1111 for the 2 cycles before that.
- Slot sequencing: an steps 1110→1101→1011→0111→1110, each slot 8 cycles, with a 1-cycle output lag after the idx change. Check the patterns 7'h19, 7'h30, 7'h24, 7'h79 in order.
- Mid-frame input change: change dig1 from 3 to 5 while idx=1. The current frame still shows 7'h30; the next frame shows 7'h12.
- Leading zero with blank_lz=1 and dig3=0: the digit-3 slot has an[3]=0 with seg=7'h7F. With blank_lz=0 the same slot shows 7'h40.
- Invalid BCD: dig2=4'hC gives 7'h3F in the digit-2 slot. With dp_in=4'b0100, dp=0 only in the lit part of the digit-2 slot.
- Enable and async reset:
  - Drop en for 5 cycles mid-slot: an=1111 from the next cycle, and the scan resumes in phase.
  - Assert rst asynchronously mid-slot: an=1111 and seg=7'h7F immediately, without waiting for a clock edge.
